ksa_shuffle: RTL and testbench



---
 rtl/rc4_pkg.sv | 27 ++
 rtl/ksa_shuffle_if.sv | 31 +++
 rtl/ksa_shuffle.sv | 113 +++++++++++
 tb/tb_ksa_shuffle.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rc4_pkg : shared RC4 types and constants (init, KSA, PRGA stages)          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package rc4_pkg;

  typedef logic [7:0] byte_t;

  localparam int    S_SIZE = 256;
  localparam byte_t S_LAST = 8'hFF;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    RD_I  = 4'd1,
    WT_I  = 4'd2,
    GET_I = 4'd3,
    RD_J  = 4'd4,
    WT_J  = 4'd5,
    GET_J = 4'd6,
    WR_I  = 4'd7,
    WR_J  = 4'd8,
    DONE  = 4'd9
  } ksa_state_t;

endpackage
`default_nettype wire

// File: rtl/ksa_shuffle_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ksa_shuffle_if : start/key/S-RAM port bundle for the KSA shuffle stage     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface ksa_shuffle_if #(
  parameter int KEY_LEN = 3
);
  import rc4_pkg::*;

  logic                   start;
  logic [8*KEY_LEN-1:0]   secret_key;
  byte_t                  s_q;
  byte_t                  s_address;
  byte_t                  s_data;
  logic                   s_wren;
  logic                   finish;

  // master is the top level that owns the RAM and sequences the stages
  modport master (
    output start, secret_key, s_q,
    input  s_address, s_data, s_wren, finish
  );

  modport slave (
    input  start, secret_key, s_q,
    output s_address, s_data, s_wren, finish
  );

endinterface
`default_nettype wire

// File: rtl/ksa_shuffle.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ksa_shuffle : RC4 key schedule, permutes S in place over the shared RAM    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ksa_shuffle
  import rc4_pkg::*;
#(
  parameter int KEY_LEN = 3
) (
  input  logic          clk,
  input  logic          reset,
  ksa_shuffle_if.slave  bus
);

  localparam int             K_W    = 5;
  localparam logic [K_W-1:0] K_LAST = K_W'(KEY_LEN - 1);

  ksa_state_t     r_state;
  byte_t          r_i;
  byte_t          r_j;
  byte_t          r_s_i;
  byte_t          r_s_j;
  logic [K_W-1:0] r_k;

  int             w_key_sel;
  byte_t          w_key_byte;
  byte_t          w_address;
  byte_t          w_data;
  logic           w_wren;

  // key[0] sits in the most-significant byte, so walk the bytes downward
  always_comb begin
    w_key_sel  = KEY_LEN - 1 - int'(r_k);
    w_key_byte = bus.secret_key[w_key_sel*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_s_i   <= '0;
      r_s_j   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_state <= RD_I;
          end
        end
        RD_I:  r_state <= WT_I;
        WT_I:  r_state <= GET_I;
        GET_I: begin
          r_s_i   <= bus.s_q;
          r_j     <= r_j + bus.s_q + w_key_byte;
          r_state <= RD_J;
        end
        RD_J:  r_state <= WT_J;
        WT_J:  r_state <= GET_J;
        GET_J: begin
          r_s_j   <= bus.s_q;
          r_state <= WR_I;
        end
        WR_I:  r_state <= WR_J;
        WR_J: begin
          if (r_i == S_LAST) begin
            r_state <= DONE;
          end else begin
            r_i     <= r_i + 8'd1;
            r_k     <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
            r_state <= RD_I;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Moore decode; i == j simply writes the same byte twice
  always_comb begin
    w_address = '0;
    w_data    = '0;
    w_wren    = 1'b0;
    case (r_state)
      RD_I, WT_I: w_address = r_i;
      RD_J, WT_J: w_address = r_j;
      WR_I: begin
        w_address = r_i;
        w_data    = r_s_j;
        w_wren    = 1'b1;
      end
      WR_J: begin
        w_address = r_j;
        w_data    = r_s_i;
        w_wren    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.s_address = w_address;
  assign bus.s_data    = w_data;
  assign bus.s_wren    = w_wren;
  assign bus.finish    = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_ksa_shuffle.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ksa_shuffle : scoreboard bench, two DUTs (KEY_LEN 3 and 1) on RAM models|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_ksa_shuffle;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       init_req;
  logic [7:0] mem [2][256];
  logic [7:0] ar0, ar1;
  wr_t        exp_q [2][$];
  int         tests = 0;
  int         fails = 0;

  ksa_shuffle_if #(.KEY_LEN(3)) b3 ();
  ksa_shuffle_if #(.KEY_LEN(1)) b1 ();

  ksa_shuffle #(.KEY_LEN(3)) dut3 (.clk(clk), .reset(reset), .bus(b3.slave));
  ksa_shuffle #(.KEY_LEN(1)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));

  always #5 clk = ~clk;

  // registered-address RAM: data appears two cycles after the address is driven
  always @(posedge clk) begin
    ar0    <= b3.s_address;
    ar1    <= b1.s_address;
    b3.s_q <= mem[0][ar0];
    b1.s_q <= mem[1][ar1];
    if (b3.s_wren) mem[0][b3.s_address] <= b3.s_data;
    if (b1.s_wren) mem[1][b1.s_address] <= b1.s_data;
    if (init_req) for (int n = 0; n < 256; n++) begin
      mem[0][n] <= 8'(n);
      mem[1][n] <= 8'(n);
    end
  end

  function automatic logic [7:0] f_addr(input int w);
    return (w == 0) ? b3.s_address : b1.s_address;
  endfunction
  function automatic logic [7:0] f_data(input int w);
    return (w == 0) ? b3.s_data : b1.s_data;
  endfunction
  function automatic logic f_wren(input int w);
    return (w == 0) ? b3.s_wren : b1.s_wren;
  endfunction
  function automatic logic f_fin(input int w);
    return (w == 0) ? b3.finish : b1.finish;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int w, input logic v);
    if (w == 0) b3.start = v;
    else        b1.start = v;
  endtask

  task automatic init_s();
    @(negedge clk) init_req = 1'b1;
    @(negedge clk) init_req = 1'b0;
  endtask

  // One shuffle from identity S; poke_cyc re-pulses start, rst_cyc aborts with reset.
  task automatic run(input int w, input int klen, input logic [23:0] key,
                     input int poke_cyc, input int rst_cyc);
    logic [7:0] s [256];
    logic [7:0] j, t, kb;
    int         cyc, nwr;
    bit         done;
    wr_t        e;

    for (int n = 0; n < 256; n++) s[n] = 8'(n);
    j = 8'd0;
    exp_q[w].delete();
    for (int i = 0; i < 256; i++) begin
      kb = 8'(key >> (8 * (klen - 1 - (i % klen))));
      j  = j + s[i] + kb;
      exp_q[w].push_back({8'(i), s[j]});
      exp_q[w].push_back({j, s[i]});
      t = s[i]; s[i] = s[j]; s[j] = t;
    end

    @(negedge clk);
    if (w == 0) b3.secret_key = key;
    else        b1.secret_key = key[7:0];
    set_start(w, 1'b1);
    @(posedge clk);
    #1 set_start(w, 1'b0);

    cyc = 0; nwr = 0; done = 1'b0;
    while (!done && cyc < 2200) begin
      @(negedge clk);
      cyc++;
      if (f_wren(w)) begin
        nwr++;
        if (exp_q[w].size() == 0) chk("extra_write", 32'd1, 32'd0);
        else begin
          e = exp_q[w].pop_front();
          chk("wr_addr", 32'(f_addr(w)), 32'(e.a));
          chk("wr_data", 32'(f_data(w)), 32'(e.d));
        end
      end
      if (f_fin(w)) begin
        chk("finish_cycle", cyc, 2049);
        done = 1'b1;
      end
      set_start(w, (cyc == poke_cyc) ? 1'b1 : 1'b0);
      if (cyc == rst_cyc) begin
        reset = 1'b1;
        @(negedge clk);
        chk("rst_addr", 32'(f_addr(w)), 32'd0);
        chk("rst_data", 32'(f_data(w)), 32'd0);
        chk("rst_wren", 32'(f_wren(w)), 32'd0);
        chk("rst_finish", 32'(f_fin(w)), 32'd0);
        reset = 1'b0;
        exp_q[w].delete();
        return;
      end
    end

    if (!done) begin
      chk("finish_timeout", cyc, 2049);
    end else begin
      @(negedge clk);
      chk("finish_single_pulse", 32'(f_fin(w)), 32'd0);
      chk("write_count", nwr, 512);
      chk("queue_empty", exp_q[w].size(), 0);
      for (int n = 0; n < 256; n++) chk("final_s", 32'(mem[w][n]), 32'(s[n]));
    end
  endtask

  initial begin
    reset         = 1'b1;
    init_req      = 1'b1;
    b3.start      = 1'b0;
    b1.start      = 1'b0;
    b3.secret_key = '0;
    b1.secret_key = '0;
    repeat (3) @(negedge clk);
    reset    = 1'b0;
    init_req = 1'b0;

    chk("reset_addr", 32'(b3.s_address), 32'd0);
    chk("reset_data", 32'(b3.s_data), 32'd0);
    chk("reset_wren", 32'(b3.s_wren), 32'd0);
    chk("reset_finish", 32'(b3.finish), 32'd0);
    chk("reset_wren_k1", 32'(b1.s_wren), 32'd0);

    run(0, 3, 24'h010203, -1, -1);
    init_s();
    run(0, 3, 24'h000000, -1, -1);
    init_s();
    run(0, 3, 24'h000249, -1, -1);
    init_s();
    run(0, 3, 24'h000249, 500, -1);
    init_s();
    run(0, 3, 24'h000249, -1, 100);
    init_s();
    run(0, 3, 24'h000249, -1, -1);
    init_s();
    run(1, 1, 24'h000005, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
